// File: rtl/tod_pkg.sv
// Shared field widths, limits and 12-hour display encoding for the
// time-of-day counter.
package tod_pkg;

  localparam int HR_W  = 5;
  localparam int MIN_W = 6;
  localparam int SEC_W = 6;

  localparam logic [HR_W-1:0]  HR_MAX  = 5'd23;
  localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;
  localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;

  // Internal hour is 0-23; midnight and noon both show as 12.
  function automatic logic [HR_W-1:0] to_12h(input logic [HR_W-1:0] hr);
    if (hr == 5'd0)
      return 5'd12;
    else if (hr > 5'd12)
      return hr - 5'd12;
    else
      return hr;
  endfunction

endpackage

// File: rtl/tod_tick_prescaler.sv
// Divides kh_clk down to the sub-second tick; holds while run is low and
// restarts its count when a time load is accepted.
module tod_tick_prescaler #(
  parameter int TICK_DIV = 1
) (
  input  logic kh_clk,
  input  logic reset,
  input  logic run,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = run && (cnt == CNT_LAST);

  always_ff @(posedge kh_clk) begin
    if (reset)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (run)
      cnt <= tick ? '0 : cnt + CNT_W'(1);
  end

endmodule

// File: rtl/time_of_day_counter.sv
// Time-of-day counter: hr/min/sec/sub cascade with validated load,
// one-shot alarm and runtime 12/24-hour display encoding.
module time_of_day_counter
  import tod_pkg::*;
#(
  parameter int TICK_DIV    = 1,
  parameter int SUB_PER_SEC = 1000,
  parameter int SUB_W       = $clog2(SUB_PER_SEC),
  parameter int DISP_W      = 17 + SUB_W
) (
  input  logic              kh_clk,
  input  logic              reset,
  input  logic              run,
  input  logic              mode_24,
  input  logic              load_valid,
  input  logic [4:0]        load_hr,
  input  logic [5:0]        load_min,
  input  logic [5:0]        load_sec,
  output logic              load_err,
  input  logic              alarm_wr,
  input  logic [4:0]        alarm_hr,
  input  logic [5:0]        alarm_min,
  output logic              alarm_hit,
  output logic [DISP_W-1:0] disp_time,
  output logic              pm
);

  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SUB_PER_SEC - 1);

  logic             tick;
  logic             load_ok;
  logic             load_take;
  logic             alarm_match;

  logic [HR_W-1:0]  hr,  hr_n;
  logic [MIN_W-1:0] min, min_n;
  logic [SEC_W-1:0] sec, sec_n;
  logic [SUB_W-1:0] sub, sub_n;

  logic [HR_W-1:0]  alarm_hr_q;
  logic [MIN_W-1:0] alarm_min_q;
  logic             armed;
  logic [HR_W-1:0]  disp_hr;

  assign load_ok   = (load_hr <= HR_MAX) && (load_min <= MIN_MAX) && (load_sec <= SEC_MAX);
  assign load_take = load_valid && load_ok;

  tod_tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .kh_clk (kh_clk),
    .reset  (reset),
    .run    (run),
    .clr    (load_take),
    .tick   (tick)
  );

  always_comb begin
    sub_n = sub + SUB_W'(1);
    sec_n = sec;
    min_n = min;
    hr_n  = hr;
    if (sub == SUB_LAST) begin
      sub_n = '0;
      sec_n = sec + 6'd1;
      if (sec == SEC_MAX) begin
        sec_n = '0;
        min_n = min + 6'd1;
        if (min == MIN_MAX) begin
          min_n = '0;
          hr_n  = (hr == HR_MAX) ? 5'd0 : hr + 5'd1;
        end
      end
    end
  end

  // Out-of-range alarm fields can never equal a legal next time, so they never fire.
  assign alarm_match = armed && (hr_n == alarm_hr_q) && (min_n == alarm_min_q)
                       && (sec_n == '0) && (sub_n == '0);

  always_ff @(posedge kh_clk) begin
    if (reset) begin
      hr          <= '0;
      min         <= '0;
      sec         <= '0;
      sub         <= '0;
      alarm_hr_q  <= '0;
      alarm_min_q <= '0;
      armed       <= 1'b0;
      load_err    <= 1'b0;
      alarm_hit   <= 1'b0;
    end else begin
      load_err  <= load_valid && !load_ok;
      alarm_hit <= 1'b0;
      if (load_take) begin
        hr  <= load_hr;
        min <= load_min;
        sec <= load_sec;
        sub <= '0;
      end else if (tick) begin
        hr  <= hr_n;
        min <= min_n;
        sec <= sec_n;
        sub <= sub_n;
        if (alarm_match && !alarm_wr) begin
          alarm_hit <= 1'b1;
          armed     <= 1'b0;
        end
      end
      if (alarm_wr) begin
        alarm_hr_q  <= alarm_hr;
        alarm_min_q <= alarm_min;
        armed       <= 1'b1;
      end
    end
  end

  assign disp_hr   = mode_24 ? hr : to_12h(hr);
  assign disp_time = {disp_hr, min, sec, sub};
  assign pm        = (hr >= 5'd12);

endmodule

// File: tb/tb_time_of_day_counter.sv
// Scoreboard bench: two counters (TICK_DIV 1 and 3) driven in parallel and
// compared every cycle against a total-sub-count reference model.
module tb_time_of_day_counter;

  localparam int SPS    = 4;
  localparam int SUB_W  = 2;
  localparam int DISP_W = 17 + SUB_W;
  localparam int DAY    = 24 * 3600 * SPS;

  logic              kh_clk = 1'b0;
  logic              reset, run, mode_24;
  logic              load_valid, alarm_wr;
  logic [4:0]        load_hr, alarm_hr;
  logic [5:0]        load_min, load_sec, alarm_min;
  logic              load_err1, alarm_hit1, pm1;
  logic              load_err3, alarm_hit3, pm3;
  logic [DISP_W-1:0] disp1, disp3;

  always #5 kh_clk = ~kh_clk;

  time_of_day_counter #(.TICK_DIV(1), .SUB_PER_SEC(SPS)) dut1 (
    .kh_clk(kh_clk), .reset(reset), .run(run), .mode_24(mode_24),
    .load_valid(load_valid), .load_hr(load_hr), .load_min(load_min), .load_sec(load_sec),
    .load_err(load_err1), .alarm_wr(alarm_wr), .alarm_hr(alarm_hr), .alarm_min(alarm_min),
    .alarm_hit(alarm_hit1), .disp_time(disp1), .pm(pm1));

  time_of_day_counter #(.TICK_DIV(3), .SUB_PER_SEC(SPS)) dut3 (
    .kh_clk(kh_clk), .reset(reset), .run(run), .mode_24(mode_24),
    .load_valid(load_valid), .load_hr(load_hr), .load_min(load_min), .load_sec(load_sec),
    .load_err(load_err3), .alarm_wr(alarm_wr), .alarm_hr(alarm_hr), .alarm_min(alarm_min),
    .alarm_hit(alarm_hit3), .disp_time(disp3), .pm(pm3));

  typedef struct {
    int t;
    int pre;
    bit armed;
    int ah;
    int am;
  } mst_t;

  typedef struct {
    logic [DISP_W-1:0] disp;
    bit pm;
    bit err;
    bit hit;
  } exp_t;

  mst_t ms [2];
  exp_t q1 [$];
  exp_t q3 [$];
  int n_chk  = 0;
  int n_pass = 0;

  // Time is one integer count of sub-seconds since midnight.
  function automatic exp_t model_step(int k, int div);
    exp_t e;
    bit tk, ok;
    int hh, mm, ss, su, dh;
    e.err = 0;
    e.hit = 0;
    if (reset) begin
      ms[k].t = 0; ms[k].pre = 0; ms[k].armed = 0;
    end else begin
      tk = run && (ms[k].pre == div - 1);
      ok = (load_hr <= 23) && (load_min <= 59) && (load_sec <= 59);
      e.err = load_valid && !ok;
      if (load_valid && ok) begin
        ms[k].t = ((int'(load_hr) * 60 + int'(load_min)) * 60 + int'(load_sec)) * SPS;
        ms[k].pre = 0;
      end else begin
        if (run) ms[k].pre = tk ? 0 : ms[k].pre + 1;
        if (tk) begin
          ms[k].t = (ms[k].t + 1) % DAY;
          if (ms[k].armed && !alarm_wr && ms[k].ah <= 23 && ms[k].am <= 59 &&
              ms[k].t == (ms[k].ah * 60 + ms[k].am) * 60 * SPS) begin
            e.hit = 1;
            ms[k].armed = 0;
          end
        end
      end
      if (alarm_wr) begin
        ms[k].ah = int'(alarm_hr); ms[k].am = int'(alarm_min); ms[k].armed = 1;
      end
    end
    su = ms[k].t % SPS;
    ss = (ms[k].t / SPS) % 60;
    mm = (ms[k].t / (SPS * 60)) % 60;
    hh = ms[k].t / (SPS * 3600);
    dh = mode_24 ? hh : ((hh % 12 == 0) ? 12 : hh % 12);
    e.pm = (hh >= 12);
    e.disp = {5'(dh), 6'(mm), 6'(ss), 2'(su)};
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp)
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    else
      n_pass++;
  endtask

  // Inputs are set at a falling edge; model result for the next rising edge is queued.
  task automatic cycle();
    q1.push_back(model_step(0, 1));
    q3.push_back(model_step(1, 3));
    @(posedge kh_clk);
    @(negedge kh_clk);
    reset = 1'b0;
    load_valid = 1'b0;
    alarm_wr = 1'b0;
  endtask

  task automatic do_load(input int h, input int m, input int s);
    load_valid = 1'b1;
    load_hr = 5'(h); load_min = 6'(m); load_sec = 6'(s);
    cycle();
  endtask

  task automatic do_alarm(input int h, input int m);
    alarm_wr = 1'b1;
    alarm_hr = 5'(h); alarm_min = 6'(m);
    cycle();
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin : monitor
    exp_t e1, e3;
    forever begin
      @(posedge kh_clk);
      #1;
      if (q1.size() > 0 && q3.size() > 0) begin
        e1 = q1.pop_front();
        e3 = q3.pop_front();
        chk("disp_div1", 32'(disp1), 32'(e1.disp));
        chk("pm_div1", 32'(pm1), 32'(e1.pm));
        chk("load_err_div1", 32'(load_err1), 32'(e1.err));
        chk("alarm_hit_div1", 32'(alarm_hit1), 32'(e1.hit));
        chk("disp_div3", 32'(disp3), 32'(e3.disp));
        chk("pm_div3", 32'(pm3), 32'(e3.pm));
        chk("load_err_div3", 32'(load_err3), 32'(e3.err));
        chk("alarm_hit_div3", 32'(alarm_hit3), 32'(e3.hit));
      end
    end
  end

  initial begin : stim
    int r, h, m;
    reset = 1'b1; run = 1'b0; mode_24 = 1'b1;
    load_valid = 1'b0; alarm_wr = 1'b0;
    load_hr = '0; load_min = '0; load_sec = '0;
    alarm_hr = '0; alarm_min = '0;
    @(negedge kh_clk);

    reset = 1'b1; cycle();
    mode_24 = 1'b0; reset = 1'b1; cycle();
    mode_24 = 1'b1; run = 1'b1; run_n(4);

    do_load(23, 59, 59); run_n(4);
    mode_24 = 1'b0; do_load(23, 59, 59); run_n(4);

    do_load(13, 5, 0); run_n(2);
    mode_24 = 1'b1; run_n(2);

    do_load(24, 10, 0); run_n(2);
    do_load(10, 60, 0); run_n(2);
    do_load(10, 10, 61); run_n(2);
    do_load(5, 6, 7); run_n(2);

    do_alarm(7, 30); do_load(7, 29, 59); run_n(15);
    do_load(7, 29, 59); run_n(15);
    do_alarm(7, 30); do_load(7, 30, 0); run_n(4);
    do_alarm(7, 30); do_load(7, 29, 59); run_n(3);
    do_alarm(8, 0); run_n(3);
    do_alarm(24, 0); do_load(23, 59, 59); run_n(6);

    do_load(1, 2, 3);
    for (int i = 0; i < 40; i++) begin
      run = 1'($urandom_range(0, 1));
      cycle();
    end
    run = 1'b1; run_n(2);
    reset = 1'b1; cycle();
    run_n(3);

    for (int i = 0; i < 600; i++) begin
      run = ($urandom_range(0, 3) != 0);
      mode_24 = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 31);
      if (r == 0) begin
        load_valid = 1'b1;
        load_hr = 5'($urandom_range(0, 25));
        load_min = 6'($urandom_range(0, 61));
        load_sec = 6'($urandom_range(0, 61));
      end else if (r == 1) begin
        alarm_wr = 1'b1;
        alarm_hr = 5'($urandom_range(0, 24));
        alarm_min = 6'($urandom_range(0, 60));
      end else if (r == 2) begin
        h = $urandom_range(0, 23);
        m = $urandom_range(0, 58);
        alarm_wr = 1'b1; alarm_hr = 5'(h); alarm_min = 6'(m + 1);
        load_valid = 1'b1; load_hr = 5'(h); load_min = 6'(m); load_sec = 6'd59;
      end
      cycle();
    end

    run_n(2);
    chk("queue_drained", 32'(q1.size() + q3.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
